// File: rtl/viterbi_tb_ctrl.sv
// Traceback controller for a 4-state Viterbi decoder.
// Fills a 2L-deep survivor ring, traces back 2L steps from the min-metric state, then streams L bits oldest first.
module viterbi_tb_ctrl #(
  parameter int TB_LEN = 8,
  parameter int PM_W   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            d0,
  input  logic            d1,
  input  logic            d2,
  input  logic            d3,
  input  logic [PM_W-1:0] pm0,
  input  logic [PM_W-1:0] pm1,
  input  logic [PM_W-1:0] pm2,
  input  logic [PM_W-1:0] pm3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_bit,
  output logic            busy
);

  localparam int DEPTH = 2 * TB_LEN;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam logic [CW-1:0] FIRST_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] NEXT_CNT  = CW'(TB_LEN);
  localparam logic [AW-1:0] K_LAST    = AW'(DEPTH - 1);
  localparam logic [AW-1:0] K_HALF    = AW'(TB_LEN);
  localparam logic [AW-1:0] POP_LAST  = AW'(TB_LEN - 1);

  typedef enum logic [1:0] {FILL, TRACE, OUTPUT} state_t;

  state_t                  state_q, state_d;
  logic [DEPTH-1:0][3:0]   mem_q, mem_d;
  logic [AW-1:0]           wp_q, wp_d, rp_q, rp_d, k_q, k_d;
  logic [CW-1:0]           sym_cnt_q, sym_cnt_d, cnt_inc;
  logic                    primed_q, primed_d;
  logic [1:0]              best_q, best_d, s_q, s_d, min_idx;
  logic [TB_LEN-1:0]       lifo_q, lifo_d;
  logic [PM_W-1:0]         min_pm;
  logic                    acc, dec;

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    min_idx = 2'd0;
    min_pm  = pm0;
    if (pm1 < min_pm) begin min_idx = 2'd1; min_pm = pm1; end
    if (pm2 < min_pm) begin min_idx = 2'd2; min_pm = pm2; end
    if (pm3 < min_pm) begin min_idx = 2'd3; min_pm = pm3; end
  end

  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    wp_d      = wp_q;
    rp_d      = rp_q;
    k_d       = k_q;
    sym_cnt_d = sym_cnt_q;
    primed_d  = primed_q;
    best_d    = best_q;
    s_d       = s_q;
    lifo_d    = lifo_q;
    in_ready  = (state_q == FILL);
    busy      = (state_q != FILL);
    out_valid = (state_q == OUTPUT);
    out_bit   = out_valid & lifo_q[0];
    acc       = in_valid & in_ready;
    cnt_inc   = sym_cnt_q + 1'b1;
    dec       = mem_q[rp_q][s_q];
    case (state_q)
      FILL: begin
        if (acc) begin
          mem_d[wp_q] = {d3, d2, d1, d0};
          wp_d        = wp_q + 1'b1;
          sym_cnt_d   = cnt_inc;
          best_d      = min_idx;
          if ((!primed_q && cnt_inc == FIRST_CNT) || (primed_q && cnt_inc == NEXT_CNT)) begin
            state_d   = TRACE;
            sym_cnt_d = '0;
            primed_d  = 1'b1;
            rp_d      = wp_q;
            s_d       = min_idx;
            k_d       = '0;
          end
        end
      end
      TRACE: begin
        // First L steps only converge onto the survivor path.
        if (k_q >= K_HALF) lifo_d = {lifo_q[TB_LEN-2:0], s_q[1]};
        s_d  = {s_q[0], dec};
        rp_d = rp_q - 1'b1;
        k_d  = k_q + 1'b1;
        if (k_q == K_LAST) begin
          state_d = OUTPUT;
          k_d     = '0;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          lifo_d = lifo_q >> 1;
          k_d    = k_q + 1'b1;
          if (k_q == POP_LAST) begin
            state_d = FILL;
            k_d     = '0;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FILL;
      mem_q     <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      k_q       <= '0;
      sym_cnt_q <= '0;
      primed_q  <= 1'b0;
      best_q    <= '0;
      s_q       <= '0;
      lifo_q    <= '0;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      k_q       <= k_d;
      sym_cnt_q <= sym_cnt_d;
      primed_q  <= primed_d;
      best_q    <= best_d;
      s_q       <= s_d;
      lifo_q    <= lifo_d;
    end
  end

endmodule

// File: tb/tb_viterbi_tb_ctrl.sv
// Scoreboard bench for viterbi_tb_ctrl: a queue-based traceback model predicts each window's bits,
// a negedge monitor pops and compares every accepted output bit.
module tb_viterbi_tb_ctrl;
  localparam int L  = 8;
  localparam int PW = 4;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, d0, d1, d2, d3;
  logic [PW-1:0] pm0, pm1, pm2, pm3;
  logic out_valid, out_ready, out_bit, busy;

  always #5 clk = ~clk;

  viterbi_tb_ctrl #(.TB_LEN(L), .PM_W(PW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .pm0(pm0), .pm1(pm1), .pm2(pm2), .pm3(pm3),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit), .busy(busy)
  );

  int   checks = 0;
  int   fails  = 0;
  int   pop_cnt = 0;
  bit   exp_q[$];
  logic [3:0] hist_d[$];
  bit   u_hist[$];
  bit   truth_mode = 1'b0;
  bit   hold = 1'b0;
  bit   rnd  = 1'b0;

  task automatic check(string name, int act, int expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Reference: on each window boundary walk the accepted-symbol history back 2L symbols
  // from the argmin state; the older L states yield the bits, emitted oldest first.
  task automatic model_accept(logic [3:0] d, logic [3:0][PW-1:0] pmv, bit ub);
    int n;
    logic [1:0] s;
    logic [3:0] dv;
    bit w[L];
    hist_d.push_back(d);
    u_hist.push_back(ub);
    n = hist_d.size();
    if (n >= 2*L && (n - 2*L) % L == 0) begin
      s = 2'd0;
      for (int i = 1; i < 4; i++) if (pmv[i] < pmv[s]) s = 2'(i);
      for (int k = 0; k < 2*L; k++) begin
        if (k >= L) w[k-L] = s[1];
        dv = hist_d[n-1-k];
        s  = {s[0], dv[s]};
      end
      if (truth_mode) for (int j = 0; j < L; j++) exp_q.push_back(u_hist[n-2*L+j]);
      else            for (int j = L-1; j >= 0; j--) exp_q.push_back(w[j]);
    end
  endtask

  task automatic send(logic [3:0] d, logic [3:0][PW-1:0] pmv, bit ub);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 300) begin @(negedge clk); t++; end
    if (!in_ready) begin
      checks++; fails++;
      $display("FAIL send_timeout: in_ready stayed %0b, required 1", in_ready);
      return;
    end
    in_valid = 1'b1;
    {d3, d2, d1, d0} = d;
    {pm3, pm2, pm1, pm0} = pmv;
    @(posedge clk);
    model_accept(d, pmv, ub);
  endtask

  task automatic send_rand();
    logic [3:0][PW-1:0] pmv;
    for (int i = 0; i < 4; i++) pmv[i] = PW'($urandom_range(0, 15));
    send(4'($urandom), pmv, 1'b0);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(string name);
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 3000) begin @(negedge clk); t++; end
    check(name, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    in_valid = 1'b0;
    exp_q.delete(); hist_d.delete(); u_hist.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (hold)     out_ready = 1'b0;
      else if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      else          out_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      pop_cnt++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL extra_bit: got out_bit=%0b, required no output", out_bit);
      end else begin
        bit e;
        e = exp_q.pop_front();
        if (out_bit !== e) begin
          fails++;
          $display("FAIL out_bit #%0d: got %0b expected %0b", pop_cnt, out_bit, e);
        end
      end
    end
  end

  initial begin
    int n, p0;
    bit seen, ob;
    logic [1:0] p, s;
    logic [3:0] dv;
    logic [3:0][PW-1:0] pmv;
    bit u[8];
    u = '{1, 0, 1, 1, 0, 0, 1, 0};
    reset = 1'b1; in_valid = 1'b0;
    {d3, d2, d1, d0} = 4'h0; pm0 = '0; pm1 = '0; pm2 = '0; pm3 = '0;

    // T1: reset values, abort mid-TRACE, then fresh operation
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_bit", out_bit, 0);
    #7 reset = 1'b0;
    for (int i = 0; i < 2*L; i++) send_rand();
    idle();
    repeat (4) @(negedge clk);
    check("t1_busy_trace", busy, 1);
    check("t1_in_ready_trace", in_ready, 0);
    #2 reset = 1'b1;
    exp_q.delete(); hist_d.delete(); u_hist.delete();
    #1;
    check("t1_busy_on_reset", busy, 0);
    check("t1_out_valid_on_reset", out_valid, 0);
    @(negedge clk); reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (out_valid || busy) seen = 1'b1; end
    check("t1_nothing_emitted", seen, 0);
    for (int i = 0; i < 2*L; i++) send_rand();
    idle();
    drain("t1_fresh_drain");

    // T2: all-zero decisions, latency of first out_valid
    do_reset();
    for (int i = 0; i < 2*L; i++) send(4'b0000, {PW'(3), PW'(3), PW'(3), PW'(0)}, 1'b0);
    n = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      if (n == 0) in_valid = 1'b0;
      n++;
      seen = out_valid;
    end
    check("t2_first_valid_cycle", n, 2*L + 1);
    drain("t2_drain");

    // T3: ideal decisions along the true path; output is u delayed by a window
    do_reset();
    truth_mode = 1'b1; rnd = 1'b1;
    p = 2'd0;
    for (int j = 0; j < 4*L; j++) begin
      s = {u[j%8], p[1]};
      dv = 4'($urandom);
      dv[s] = p[0];
      pmv = {4{PW'(5)}};
      pmv[s] = '0;
      send(dv, pmv, u[j%8]);
      p = s;
    end
    idle();
    drain("t3_drain");
    truth_mode = 1'b0; rnd = 1'b0;

    // T4: tied metrics, traceback must start at state 0
    do_reset();
    for (int i = 0; i < 2*L; i++) send(4'b1010, {PW'(1), PW'(0), PW'(1), PW'(0)}, 1'b0);
    idle();
    drain("t4_drain");

    // T5: backpressure mid-OUTPUT
    do_reset();
    for (int i = 0; i < 2*L; i++) send_rand();
    idle();
    p0 = pop_cnt;
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    check("t5_out_valid_seen", out_valid, 1);
    repeat (2) @(negedge clk);
    hold = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ob = out_bit;
    repeat (5) begin
      @(negedge clk);
      check("t5_bit_stable", out_bit, ob);
      check("t5_in_ready_low", in_ready, 0);
      check("t5_out_valid_held", out_valid, 1);
    end
    hold = 1'b0;
    drain("t5_drain");
    check("t5_pop_count", pop_cnt - p0, L);

    // T6: 64 symbols back-to-back, ring wraps 4 times
    do_reset();
    rnd = 1'b1;
    p0 = pop_cnt;
    for (int i = 0; i < 8*L; i++) send_rand();
    idle();
    drain("t6_drain");
    check("t6_pop_count", pop_cnt - p0, 7*L);
    rnd = 1'b0;

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
